stopwatch_lap_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/lap_buffer.sv | 29 ++
 rtl/stopwatch_lap_ctrl.sv | 174 +++++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch encodings: control-FSM status values and lap-display states.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } status_t;

    typedef enum logic [1:0] {
        LV_LIVE   = 2'b00,
        LV_HOLD   = 2'b01,
        LV_BROWSE = 2'b10
    } lap_state_t;

endpackage

// File: rtl/lap_buffer.sv
// Lap storage: DEPTH x TIME_W registers, one synchronous write port and two
// combinational read ports. Data is deliberately not reset.
module lap_buffer #(
    parameter int TIME_W = 24,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [TIME_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [TIME_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [TIME_W-1:0] rdata_b
);

    logic [TIME_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Lap capture and display sequencing (live / held lap / browsed laps).
// Define LAP_SPLIT_EN to display lap splits instead of absolute lap times.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W   = 24,
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 status,
    input  logic [TIME_W-1:0]          time_in,
    input  logic                       lap_btn,
    input  logic                       recall_btn,
    input  logic                       clear,
    output logic [TIME_W-1:0]          disp_time,
    output logic                       disp_sel,
    output logic [$clog2(DEPTH)-1:0]   disp_idx,
    output logic [$clog2(DEPTH+1)-1:0] lap_count,
    output logic                       lap_full,
    output logic                       lap_drop
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);

    lap_state_t        state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [TIME_W-1:0] disp_time_reg, disp_time_next;
    logic              disp_sel_reg, disp_sel_next;
    logic [IDX_W-1:0]  disp_idx_reg, disp_idx_next;
    logic [CNT_W-1:0]  lap_count_reg, lap_count_next;
    logic              lap_drop_reg, lap_drop_next;

    logic              running, lap_ok, lap_rej, buf_we;
    logic [CNT_W-1:0]  cnt_m1;
    logic [IDX_W-1:0]  cnt_idx, last_idx, view_idx, prev_idx;
    logic [TIME_W-1:0] rd_a, rd_b, cap_val, view_val;

    assign running  = (status == ST_RUNNING);
    assign lap_ok   = lap_btn && running && (lap_count_reg != CNT_FULL);
    assign lap_rej  = lap_btn && running && (lap_count_reg == CNT_FULL);
    assign buf_we   = lap_ok && !clear;
    assign cnt_m1   = lap_count_reg - CNT_ONE;
    assign cnt_idx  = lap_count_reg[IDX_W-1:0];
    assign last_idx = cnt_m1[IDX_W-1:0];

    // Entry that will be on screen after this edge if we browse; the second
    // port reads its predecessor (or the previous lap when capturing).
    assign view_idx = (state_reg == LV_BROWSE) ? disp_idx_reg + IDX_ONE : '0;
    assign prev_idx = lap_ok ? last_idx : view_idx - IDX_ONE;

    lap_buffer #(
        .TIME_W (TIME_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_lap_buffer (
        .clk     (clk),
        .we      (buf_we),
        .waddr   (cnt_idx),
        .wdata   (time_in),
        .raddr_a (view_idx),
        .rdata_a (rd_a),
        .raddr_b (prev_idx),
        .rdata_b (rd_b)
    );

`ifdef LAP_SPLIT_EN
    // The first lap's predecessor is an implicit zero.
    assign cap_val  = time_in - ((lap_count_reg == '0) ? {TIME_W{1'b0}} : rd_b);
    assign view_val = rd_a - ((view_idx == '0) ? {TIME_W{1'b0}} : rd_b);
`else
    logic unused_rd_b;
    assign unused_rd_b = ^rd_b;
    assign cap_val     = time_in;
    assign view_val    = rd_a;
`endif

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        disp_time_next = disp_time_reg;
        disp_sel_next  = disp_sel_reg;
        disp_idx_next  = disp_idx_reg;
        lap_count_next = lap_count_reg;
        lap_drop_next  = 1'b0;
        if (clear) begin
            state_next     = LV_LIVE;
            hold_next      = '0;
            disp_time_next = time_in;
            disp_sel_next  = 1'b0;
            disp_idx_next  = '0;
            lap_count_next = '0;
        end else if (lap_ok) begin
            state_next     = LV_HOLD;
            hold_next      = HOLD_INIT;
            disp_time_next = cap_val;
            disp_sel_next  = 1'b1;
            disp_idx_next  = cnt_idx;
            lap_count_next = lap_count_reg + CNT_ONE;
        end else begin
            lap_drop_next = lap_rej;
            case (state_reg)
                LV_LIVE: begin
                    disp_time_next = time_in;
                    disp_sel_next  = 1'b0;
                    if (recall_btn && !running && (lap_count_reg != '0)) begin
                        state_next     = LV_BROWSE;
                        disp_idx_next  = '0;
                        disp_sel_next  = 1'b1;
                        disp_time_next = view_val;
                    end
                end
                LV_HOLD: begin
                    if (hold_reg == '0) begin
                        state_next     = LV_LIVE;
                        disp_time_next = time_in;
                        disp_sel_next  = 1'b0;
                        disp_idx_next  = '0;
                    end else begin
                        hold_next = hold_reg - HOLD_ONE;
                    end
                end
                LV_BROWSE: begin
                    if (running || (recall_btn && disp_idx_reg == last_idx)) begin
                        state_next     = LV_LIVE;
                        disp_time_next = time_in;
                        disp_sel_next  = 1'b0;
                        disp_idx_next  = '0;
                    end else if (recall_btn) begin
                        disp_idx_next  = view_idx;
                        disp_time_next = view_val;
                    end
                end
                default: state_next = LV_LIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= LV_LIVE;
            hold_reg      <= '0;
            disp_time_reg <= '0;
            disp_sel_reg  <= 1'b0;
            disp_idx_reg  <= '0;
            lap_count_reg <= '0;
            lap_drop_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            disp_time_reg <= disp_time_next;
            disp_sel_reg  <= disp_sel_next;
            disp_idx_reg  <= disp_idx_next;
            lap_count_reg <= lap_count_next;
            lap_drop_reg  <= lap_drop_next;
        end
    end

    assign disp_time = disp_time_reg;
    assign disp_sel  = disp_sel_reg;
    assign disp_idx  = disp_idx_reg;
    assign lap_count = lap_count_reg;
    assign lap_drop  = lap_drop_reg;
    assign lap_full  = (lap_count_reg == CNT_FULL);

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Scoreboard bench for stopwatch_lap_ctrl: stimulus queues expected display
// state per cycle, a monitor compares after every clock edge.
module tb_stopwatch_lap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  status = 2'b00;
    logic [23:0] time_in = '0;
    logic        lap_btn = 1'b0;
    logic        recall_btn = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] disp_time;
    logic        disp_sel;
    logic [2:0]  disp_idx;
    logic [3:0]  lap_count;
    logic        lap_full;
    logic        lap_drop;

    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] P = 2'b10;
`ifdef LAP_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam logic [23:0] V250 = SPLIT ? 24'd150 : 24'd250;
    localparam logic [23:0] V400 = SPLIT ? 24'd150 : 24'd400;
    localparam logic [23:0] V80  = SPLIT ? 24'd10  : 24'd80;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        sel;
        logic [23:0] t;
        logic [2:0]  idx;
        logic [3:0]  cnt;
        logic        drop;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    stopwatch_lap_ctrl #(
        .TIME_W   (24),
        .DEPTH    (8),
        .HOLD_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .status     (status),
        .time_in    (time_in),
        .lap_btn    (lap_btn),
        .recall_btn (recall_btn),
        .clear      (clear),
        .disp_time  (disp_time),
        .disp_sel   (disp_sel),
        .disp_idx   (disp_idx),
        .lap_count  (lap_count),
        .lap_full   (lap_full),
        .lap_drop   (lap_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic cyc(input string tg, input logic [1:0] st, input logic [23:0] t,
                       input logic lp, input logic rc, input logic cl,
                       input logic e_sel, input logic [23:0] e_t, input logic [2:0] e_idx,
                       input logic [3:0] e_cnt, input logic e_drop);
        @(negedge clk);
        status     = st;
        time_in    = t;
        lap_btn    = lp;
        recall_btn = rc;
        clear      = cl;
        exp_q.push_back({e_sel, e_t, e_idx, e_cnt, e_drop});
        tag_q.push_back(tg);
    endtask

    // Monitor: one queued expectation per clock edge.
    initial begin
        exp_t  e;
        string tg;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                $display("txn %-9s sel=%0d time=%0d idx=%0d count=%0d full=%0d drop=%0d",
                         tg, disp_sel, disp_time, disp_idx, lap_count, lap_full, lap_drop);
                chk({tg, ".sel"},   32'(disp_sel),  32'(e.sel));
                chk({tg, ".time"},  32'(disp_time), 32'(e.t));
                chk({tg, ".idx"},   32'(disp_idx),  32'(e.idx));
                chk({tg, ".count"}, 32'(lap_count), 32'(e.cnt));
                chk({tg, ".full"},  32'(lap_full),  32'(e.cnt == 4'd8));
                chk({tg, ".drop"},  32'(lap_drop),  32'(e.drop));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk_zero(input string tg);
        chk({tg, ".sel"},   32'(disp_sel),  32'd0);
        chk({tg, ".time"},  32'(disp_time), 32'd0);
        chk({tg, ".idx"},   32'(disp_idx),  32'd0);
        chk({tg, ".count"}, 32'(lap_count), 32'd0);
        chk({tg, ".full"},  32'(lap_full),  32'd0);
        chk({tg, ".drop"},  32'(lap_drop),  32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Single lap, hold for four cycles, then live tracking
        cyc("live0",  R, 24'd90,  0, 0, 0, 0, 24'd90,  3'd0, 4'd0, 0);
        cyc("lap100", R, 24'd100, 1, 0, 0, 1, 24'd100, 3'd0, 4'd1, 0);
        cyc("hold1",  R, 24'd101, 0, 0, 0, 1, 24'd100, 3'd0, 4'd1, 0);
        cyc("hold2",  R, 24'd102, 0, 0, 0, 1, 24'd100, 3'd0, 4'd1, 0);
        cyc("hold3",  R, 24'd103, 0, 0, 0, 1, 24'd100, 3'd0, 4'd1, 0);
        cyc("back",   R, 24'd104, 0, 0, 0, 0, 24'd104, 3'd0, 4'd1, 0);
        cyc("track",  R, 24'd105, 0, 0, 0, 0, 24'd105, 3'd0, 4'd1, 0);

        // Fill the buffer, then one rejected lap
        cyc("clr", R, 24'd0, 0, 0, 1, 0, 24'd0, 3'd0, 4'd0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc("fill", R, 24'(10 * k), 1, 0, 0, 1,
                SPLIT ? 24'd10 : 24'(10 * k), 3'(k - 1), 4'(k), 0);
        end
        cyc("drop",   R, 24'd90, 1, 0, 0, 1, V80,    3'd7, 4'd8, 1);
        cyc("nodrop", R, 24'd91, 0, 0, 0, 1, V80,    3'd7, 4'd8, 0);
        cyc("fhold",  R, 24'd92, 0, 0, 0, 1, V80,    3'd7, 4'd8, 0);
        cyc("flive",  R, 24'd93, 0, 0, 0, 0, 24'd93, 3'd0, 4'd8, 0);

        // Three laps, pause, browse through them
        cyc("clr2",  P, 24'd0,   0, 0, 1, 0, 24'd0,   3'd0, 4'd0, 0);
        cyc("lap_a", R, 24'd100, 1, 0, 0, 1, 24'd100, 3'd0, 4'd1, 0);
        cyc("lap_b", R, 24'd250, 1, 0, 0, 1, V250,    3'd1, 4'd2, 0);
        cyc("lap_c", R, 24'd400, 1, 0, 0, 1, V400,    3'd2, 4'd3, 0);
        cyc("h1",    P, 24'd400, 0, 0, 0, 1, V400,    3'd2, 4'd3, 0);
        cyc("h_rec", P, 24'd400, 0, 1, 0, 1, V400,    3'd2, 4'd3, 0);
        cyc("h3",    P, 24'd400, 0, 0, 0, 1, V400,    3'd2, 4'd3, 0);
        cyc("live",  P, 24'd400, 0, 0, 0, 0, 24'd400, 3'd0, 4'd3, 0);
        cyc("lap_p", P, 24'd400, 1, 0, 0, 0, 24'd400, 3'd0, 4'd3, 0);
        cyc("br0",   P, 24'd400, 0, 1, 0, 1, 24'd100, 3'd0, 4'd3, 0);
        cyc("br1",   P, 24'd400, 0, 1, 0, 1, V250,    3'd1, 4'd3, 0);
        cyc("br2",   P, 24'd400, 0, 1, 0, 1, V400,    3'd2, 4'd3, 0);
        cyc("br_end",P, 24'd400, 0, 1, 0, 0, 24'd400, 3'd0, 4'd3, 0);

        // Browse, then resume running
        cyc("br0b",     P, 24'd400, 0, 1, 0, 1, 24'd100, 3'd0, 4'd3, 0);
        cyc("br1b",     P, 24'd400, 0, 1, 0, 1, V250,    3'd1, 4'd3, 0);
        cyc("run_exit", R, 24'd401, 0, 0, 0, 0, 24'd401, 3'd0, 4'd3, 0);
        cyc("rec_run",  R, 24'd402, 0, 1, 0, 0, 24'd402, 3'd0, 4'd3, 0);

        // Same-cycle event priority
        cyc("lap_clr", R, 24'd410, 1, 0, 1, 0, 24'd410, 3'd0, 4'd0, 0);
        cyc("lap_rec", R, 24'd500, 1, 1, 0, 1, 24'd500, 3'd0, 4'd1, 0);
        cyc("hold_r",  R, 24'd501, 0, 0, 0, 1, 24'd500, 3'd0, 4'd1, 0);

        // Asynchronous reset in the middle of a hold
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        cyc("post",  R, 24'd70, 0, 0, 0, 0, 24'd70, 3'd0, 4'd0, 0);
        cyc("lap77", R, 24'd77, 1, 0, 0, 1, 24'd77, 3'd0, 4'd1, 0);
        cyc("ph1",   R, 24'd78, 0, 0, 0, 1, 24'd77, 3'd0, 4'd1, 0);
        cyc("ph2",   R, 24'd79, 0, 0, 0, 1, 24'd77, 3'd0, 4'd1, 0);
        cyc("ph3",   P, 24'd80, 0, 0, 0, 1, 24'd77, 3'd0, 4'd1, 0);
        cyc("plive", P, 24'd80, 0, 0, 0, 0, 24'd80, 3'd0, 4'd1, 0);
        cyc("pbr0",  P, 24'd80, 0, 1, 0, 1, 24'd77, 3'd0, 4'd1, 0);
        cyc("pexit", P, 24'd80, 0, 1, 0, 0, 24'd80, 3'd0, 4'd1, 0);
        cyc("idle",  P, 24'd80, 0, 0, 0, 0, 24'd80, 3'd0, 4'd1, 0);

        repeat (2) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
